// File: rtl/tcb_lib_arbiter_if.sv
// tcb_lib_arbiter_if: bundle of IFN manager ports and one subordinate port
// around the shared-memory arbiter.
interface tcb_lib_arbiter_if #(
  parameter int IFN = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [IFN-1:0]              man_vld;
  logic [IFN-1:0]              man_lck;
  logic [IFN-1:0]              man_wen;
  logic [IFN-1:0][AW-1:0]      man_adr;
  logic [IFN-1:0][1:0]         man_siz;
  logic [IFN-1:0][DW/8-1:0]    man_byt;
  logic [IFN-1:0][DW-1:0]      man_wdt;
  logic [IFN-1:0]              man_rdy;
  logic [IFN-1:0]              man_rsv;
  logic [DW-1:0]               man_rdt;
  logic [IFN-1:0]              man_sts;

  logic                        sub_vld;
  logic                        sub_wen;
  logic [AW-1:0]               sub_adr;
  logic [1:0]                  sub_siz;
  logic [DW/8-1:0]             sub_byt;
  logic [DW-1:0]               sub_wdt;
  logic                        sub_rdy;
  logic [DW-1:0]               sub_rdt;
  logic                        sub_sts;

  modport slave (
    input  man_vld, man_lck, man_wen, man_adr,
    input  man_siz, man_byt, man_wdt,
    output man_rdy, man_rsv, man_rdt, man_sts,
    output sub_vld, sub_wen, sub_adr,
    output sub_siz, sub_byt, sub_wdt,
    input  sub_rdy, sub_rdt, sub_sts
  );

  modport master (
    output man_vld, man_lck, man_wen, man_adr,
    output man_siz, man_byt, man_wdt,
    input  man_rdy, man_rsv, man_rdt, man_sts,
    input  sub_vld, sub_wen, sub_adr,
    input  sub_siz, sub_byt, sub_wdt,
    output sub_rdy, sub_rdt, sub_sts
  );
endinterface

// File: rtl/tcb_lib_arbiter.sv
// tcb_lib_arbiter: round-robin TCB arbiter with lock support and
// fixed-delay response routing back to the issuing manager.
module tcb_lib_arbiter #(
  parameter int IFN = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int DLY = 1
) (
  input logic clk,
  input logic rst,
  tcb_lib_arbiter_if.slave bus
);
  localparam int IW = (IFN > 1) ? $clog2(IFN) : 1;

  logic [IW-1:0]  ptr;
  logic [IW-1:0]  own_idx;
  logic           own_vld;
  logic [IW-1:0]  gid;
  logic [IW-1:0]  nxt;
  logic           gany;
  logic           xfr;
  logic [IFN-1:0] gnt;
  logic [IFN-1:0] rsv;
  int             j;

  // Grant search: locked owner only, else first requester from ptr.
  always_comb begin
    gid  = '0;
    gany = 1'b0;
    j    = 0;
    if (own_vld) begin
      if (bus.man_vld[own_idx]) begin
        gany = 1'b1;
        gid  = own_idx;
      end
    end else begin
      for (int k = 0; k < IFN; k++) begin
        j = int'(ptr) + k;
        if (j >= IFN) j = j - IFN;
        if (!gany && bus.man_vld[j]) begin
          gany = 1'b1;
          gid  = IW'(j);
        end
      end
    end
    gnt = (rst && gany) ? (IFN'(1) << gid) : '0;
    nxt = (int'(gid) >= IFN - 1) ? '0 : gid + IW'(1);
  end

  assign xfr         = rst & gany & bus.sub_rdy;
  assign bus.sub_vld = rst & gany;
  assign bus.man_rdy = bus.sub_rdy ? gnt : '0;

  // Request mux: granted manager's fields, zero when idle or in reset.
  always_comb begin
    bus.sub_wen = 1'b0;
    bus.sub_adr = '0;
    bus.sub_siz = '0;
    bus.sub_byt = '0;
    bus.sub_wdt = '0;
    if (rst && gany) begin
      bus.sub_wen = bus.man_wen[gid];
      bus.sub_adr = bus.man_adr[gid];
      bus.sub_siz = bus.man_siz[gid];
      bus.sub_byt = bus.man_byt[gid];
      bus.sub_wdt = bus.man_wdt[gid];
    end
  end

  // Priority pointer and lock owner advance only on a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      own_vld <= 1'b0;
      own_idx <= '0;
    end else if (xfr) begin
      ptr     <= nxt;
      own_vld <= bus.man_lck[gid];
      own_idx <= gid;
    end
  end

  generate
    if (DLY == 0) begin : g_comb
      assign rsv = xfr ? gnt : '0;
    end else begin : g_pipe
      logic [DLY-1:0]         pv;
      logic [DLY-1:0][IW-1:0] pi;

      // Response ownership pipeline, shifts every cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pv <= '0;
          pi <= '0;
        end else begin
          pv[0] <= xfr;
          pi[0] <= gid;
          for (int s = 1; s < DLY; s++) begin
            pv[s] <= pv[s-1];
            pi[s] <= pi[s-1];
          end
        end
      end

      assign rsv = pv[DLY-1] ? (IFN'(1) << pi[DLY-1]) : '0;
    end
  endgenerate

  assign bus.man_rsv = rsv;
  assign bus.man_sts = bus.sub_sts ? rsv : '0;
  assign bus.man_rdt = bus.sub_rdt;
endmodule

// File: tb/tb_tcb_lib_arbiter.sv
// tb_tcb_lib_arbiter: vector table plus response scoreboard against a
// simple memory subordinate with a two-cycle response delay.
module tb_tcb_lib_arbiter;
  localparam int IFN = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int DLY = 2;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] lck;
    logic [3:0] wen;
    logic       rdy;
    logic       sts;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    int          port;
    bit          rd;
    logic [31:0] dat;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  vec_t vq[$];
  sb_t  sbq[$];

  logic [31:0] adr_tab [4];
  logic [31:0] wdt_tab [4];
  logic [31:0] emem [256];
  logic [31:0] smem [256];
  logic [31:0] spipe [DLY];
  logic [31:0] sd;

  tcb_lib_arbiter_if #(.IFN(IFN), .AW(AW), .DW(DW)) bus ();

  tcb_lib_arbiter #(
    .IFN(IFN), .AW(AW), .DW(DW), .DLY(DLY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory subordinate: read data appears DLY cycles after the transfer.
  always @(posedge clk) begin
    sd = '0;
    if (bus.sub_vld && bus.sub_rdy) begin
      sd = smem[bus.sub_adr[7:0]];
      if (bus.sub_wen) smem[bus.sub_adr[7:0]] = bus.sub_wdt;
    end
    for (int s = DLY - 1; s > 0; s--) spipe[s] <= spipe[s-1];
    spipe[0] <= sd;
  end

  assign bus.sub_rdt = spipe[DLY-1];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic add(logic [3:0] vld, logic [3:0] lck, logic [3:0] wen,
                     logic rdy, logic sts, logic [3:0] exp);
    vec_t v;
    v.vld = vld; v.lck = lck; v.wen = wen;
    v.rdy = rdy; v.sts = sts; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic apply(vec_t v);
    sb_t         e;
    logic [3:0]  ersv;
    int          p;
    logic [31:0] a;
    bus.man_vld = v.vld;
    bus.man_lck = v.lck;
    bus.man_wen = v.wen;
    bus.sub_rdy = v.rdy;
    bus.sub_sts = v.sts;
    @(negedge clk);
    chk("man_rdy", 32'(bus.man_rdy), 32'(v.exp));
    ersv = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      ersv = 4'b0001 << e.port;
      if (e.rd) chk("man_rdt", bus.man_rdt, e.dat);
    end
    chk("man_rsv", 32'(bus.man_rsv), 32'(ersv));
    chk("man_sts", 32'(bus.man_sts), 32'(v.sts ? ersv : 4'b0000));
    if (v.exp != 4'b0000) begin
      p = 0;
      for (int i = 0; i < 4; i++) if (v.exp[i]) p = i;
      a = adr_tab[p];
      chk("sub_adr", bus.sub_adr, a);
      e.due  = cyc + DLY;
      e.port = p;
      e.rd   = !v.wen[p];
      e.dat  = emem[a[7:0]];
      sbq.push_back(e);
      if (v.wen[p]) emem[a[7:0]] = wdt_tab[p];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    adr_tab[0] = 32'h10; adr_tab[1] = 32'h40;
    adr_tab[2] = 32'h30; adr_tab[3] = 32'h50;
    wdt_tab[0] = 32'h0000_1111; wdt_tab[1] = 32'hDEAD_BEEF;
    wdt_tab[2] = 32'h2222_3333; wdt_tab[3] = 32'h4444_5555;
    for (int i = 0; i < 256; i++) begin
      emem[i] = 32'hC0DE_0000 | 32'(i);
      smem[i] = 32'hC0DE_0000 | 32'(i);
    end
    for (int s = 0; s < DLY; s++) spipe[s] = '0;
    for (int i = 0; i < 4; i++) begin
      bus.man_adr[i] = adr_tab[i];
      bus.man_wdt[i] = wdt_tab[i];
      bus.man_siz[i] = 2'd2;
      bus.man_byt[i] = 4'hF;
    end
    bus.man_vld = 4'b1111;
    bus.man_lck = 4'b0000;
    bus.man_wen = 4'b0000;
    bus.sub_rdy = 1'b1;
    bus.sub_sts = 1'b1;

    // round robin, single requester, wrap, ready toggling, lock, status
    add(4'b0011, 4'b0000, 4'b0000, 1, 0, 4'b0001);
    add(4'b0011, 4'b0000, 4'b0000, 1, 0, 4'b0010);
    add(4'b0011, 4'b0000, 4'b0000, 1, 0, 4'b0001);
    add(4'b0011, 4'b0000, 4'b0000, 1, 0, 4'b0010);
    add(4'b0100, 4'b0000, 4'b0000, 1, 0, 4'b0100);
    add(4'b0100, 4'b0000, 4'b0000, 1, 0, 4'b0100);
    add(4'b0100, 4'b0000, 4'b0000, 1, 0, 4'b0100);
    add(4'b1001, 4'b0000, 4'b0000, 1, 0, 4'b1000);
    add(4'b1001, 4'b0000, 4'b0000, 1, 0, 4'b0001);
    add(4'b1111, 4'b0000, 4'b0000, 1, 0, 4'b0010);
    add(4'b1111, 4'b0000, 4'b0000, 1, 0, 4'b0100);
    add(4'b1111, 4'b0000, 4'b0000, 1, 0, 4'b1000);
    add(4'b0011, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    add(4'b0011, 4'b0000, 4'b0000, 1, 0, 4'b0001);
    add(4'b0011, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    add(4'b0011, 4'b0000, 4'b0000, 1, 0, 4'b0010);
    add(4'b0001, 4'b0000, 4'b0000, 1, 0, 4'b0001);
    add(4'b0011, 4'b0010, 4'b0010, 1, 0, 4'b0010);
    add(4'b0011, 4'b0000, 4'b0000, 1, 0, 4'b0010);
    add(4'b0011, 4'b0000, 4'b0000, 1, 0, 4'b0001);
    add(4'b0010, 4'b0010, 4'b0000, 1, 0, 4'b0010);
    add(4'b0001, 4'b0000, 4'b0000, 1, 0, 4'b0000);
    add(4'b0101, 4'b0000, 4'b0000, 1, 0, 4'b0000);
    add(4'b0011, 4'b0000, 4'b0000, 1, 0, 4'b0010);
    add(4'b0101, 4'b0000, 4'b0000, 1, 0, 4'b0100);
    add(4'b0010, 4'b0000, 4'b0000, 1, 0, 4'b0010);
    add(4'b0001, 4'b0000, 4'b0000, 1, 0, 4'b0001);
    add(4'b0000, 4'b0000, 4'b0000, 1, 1, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000);

    // outputs held quiet during reset even with every port requesting
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_man_rdy", 32'(bus.man_rdy), 32'h0);
    chk("rst_man_rsv", 32'(bus.man_rsv), 32'h0);
    chk("rst_man_sts", 32'(bus.man_sts), 32'h0);
    chk("rst_sub_vld", 32'(bus.sub_vld), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (vq[i]) apply(vq[i]);

    // reset in the middle of a lock with a response in flight
    v.vld = 4'b0001; v.lck = 4'b0001; v.wen = 4'b0000;
    v.rdy = 1'b1; v.sts = 1'b0; v.exp = 4'b0001;
    apply(v);
    bus.man_vld = 4'b0011;
    bus.man_lck = 4'b0000;
    bus.sub_sts = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_man_rdy", 32'(bus.man_rdy), 32'h0);
    chk("mid_rst_man_rsv", 32'(bus.man_rsv), 32'h0);
    chk("mid_rst_man_sts", 32'(bus.man_sts), 32'h0);
    chk("mid_rst_sub_vld", 32'(bus.sub_vld), 32'h0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    v.vld = 4'b1001; v.lck = 4'b0000; v.sts = 1'b1; v.exp = 4'b0001;
    apply(v);
    v.vld = 4'b1010; v.sts = 1'b0; v.exp = 4'b0010;
    apply(v);
    v.vld = 4'b0000; v.exp = 4'b0000;
    apply(v);
    apply(v);
    apply(v);
    chk("sb_empty", 32'(sbq.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
